// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor: BTB entry layout,
// 2-bit counter encodings and default sizing.
package bp_pkg;

    localparam int ENTRIES_DEF = 16;
    localparam int IDXW_DEF    = 4;

    // Tag field sized for the smallest legal index (IDXW=2); narrower tags are zero-extended.
    localparam int TAG_W = 28;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
    } bp_entry_t;

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc, input int unsigned idxw);
        return TAG_W'(pc >> (idxw + 32'd2));
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline-facing signal bundle of the branch predictor; master is the core
// pipeline, slave is the predictor.
interface bp_if;
    logic [31:0] PCF;
    logic        StallD;
    logic        StallE;
    logic        FlushD;
    logic        FlushE;
    logic        BranchE;
    logic        BranchTakenE;
    logic [31:0] ALUResultE;
    logic [31:0] PCPlus8E;
    logic        is_branchF;
    logic        PredictTakenF;
    logic [31:0] PredictedBranchPC;
    logic        WrongPredictionE;

    modport master (
        output PCF, StallD, StallE, FlushD, FlushE,
               BranchE, BranchTakenE, ALUResultE, PCPlus8E,
        input  is_branchF, PredictTakenF, PredictedBranchPC, WrongPredictionE
    );

    modport slave (
        input  PCF, StallD, StallE, FlushD, FlushE,
               BranchE, BranchTakenE, ALUResultE, PCPlus8E,
        output is_branchF, PredictTakenF, PredictedBranchPC, WrongPredictionE
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating counter step: moves toward strong-taken on a taken
// outcome and toward strong-not-taken otherwise.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Next counter value, saturating at both ends.
    always_comb begin
        ctr_next = ctr;
        case (ctr)
            CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  ctr_next = taken ? CTR_ST  : CTR_WT;
            default: ctr_next = CTR_SNT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup, F->D->E
// prediction record, E-stage misprediction detection and BTB update.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int IDXW    = IDXW_DEF
)
(
    input  logic clk,
    input  logic reset,
    bp_if.slave  bus
);

    bp_entry_t        btb_r [ENTRIES];

    logic             pred_taken_d_r;
    logic [31:0]      pred_target_d_r;
    logic             pred_taken_e_r;
    logic [31:0]      pred_target_e_r;

    logic [IDXW-1:0]  idx_f_s;
    bp_entry_t        entry_f_s;
    logic             hit_f_s;

    logic [31:0]      br_pc_s;
    logic [IDXW-1:0]  idx_e_s;
    logic [TAG_W-1:0] tag_e_s;
    bp_entry_t        entry_e_s;
    logic             hit_e_s;
    logic [1:0]       ctr_next_s;

    assign idx_f_s   = bus.PCF[IDXW+1:2];
    assign entry_f_s = btb_r[idx_f_s];
    assign hit_f_s   = entry_f_s.valid && (entry_f_s.tag == pc_tag(bus.PCF, IDXW));

    assign bus.is_branchF        = hit_f_s;
    assign bus.PredictTakenF     = hit_f_s && entry_f_s.ctr[1];
    assign bus.PredictedBranchPC = hit_f_s ? entry_f_s.target : 32'd0;

    // The E instruction's own address is recovered from its PC+8.
    assign br_pc_s   = bus.PCPlus8E - 32'd8;
    assign idx_e_s   = br_pc_s[IDXW+1:2];
    assign tag_e_s   = pc_tag(br_pc_s, IDXW);
    assign entry_e_s = btb_r[idx_e_s];
    assign hit_e_s   = entry_e_s.valid && (entry_e_s.tag == tag_e_s);

    sat_counter2 u_ctr (
        .ctr      (entry_e_s.ctr),
        .taken    (bus.BranchTakenE),
        .ctr_next (ctr_next_s)
    );

    // A non-branch that was predicted taken is a BTB alias and must be redirected.
    assign bus.WrongPredictionE = bus.BranchE
        ? ((pred_taken_e_r != bus.BranchTakenE) ||
           (pred_taken_e_r && bus.BranchTakenE && (pred_target_e_r != bus.ALUResultE)))
        : pred_taken_e_r;

    // Prediction record pipeline: flush beats stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_taken_d_r  <= 1'b0;
            pred_target_d_r <= 32'd0;
            pred_taken_e_r  <= 1'b0;
            pred_target_e_r <= 32'd0;
        end else begin
            if (bus.FlushD) begin
                pred_taken_d_r  <= 1'b0;
                pred_target_d_r <= 32'd0;
            end else if (!bus.StallD) begin
                pred_taken_d_r  <= bus.PredictTakenF;
                pred_target_d_r <= bus.PredictedBranchPC;
            end
            if (bus.FlushE) begin
                pred_taken_e_r  <= 1'b0;
                pred_target_e_r <= 32'd0;
            end else if (!bus.StallE) begin
                pred_taken_e_r  <= pred_taken_d_r;
                pred_target_e_r <= pred_target_d_r;
            end
        end
    end

    // BTB update from the resolved E instruction; a stalled E only updates when it leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_r[i] <= '0;
            end
        end else if (!bus.StallE) begin
            if (bus.BranchE) begin
                if (hit_e_s) begin
                    btb_r[idx_e_s].ctr <= ctr_next_s;
                    if (bus.BranchTakenE) begin
                        btb_r[idx_e_s].target <= bus.ALUResultE;
                    end
                end else if (bus.BranchTakenE) begin
                    btb_r[idx_e_s] <= '{valid: 1'b1, tag: tag_e_s,
                                        target: bus.ALUResultE, ctr: CTR_WT};
                end
            end else if (pred_taken_e_r && hit_e_s) begin
                btb_r[idx_e_s].valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, all compared against a behavioural BTB model.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic reset;
    bp_if bus();

    branch_predictor #(.ENTRIES(16), .IDXW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: 16 direct-mapped entries, tag = PC >> 6, counter as a plain 0..3 integer.
    int unsigned m_valid [16];
    int unsigned m_tag   [16];
    int unsigned m_tgt   [16];
    int unsigned m_ctr   [16];
    bit          m_pt_d, m_pt_e;
    int unsigned m_tg_d, m_tg_e;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        bus.PCF          = 32'd0;
        bus.StallD       = 1'b0;
        bus.StallE       = 1'b0;
        bus.FlushD       = 1'b1;
        bus.FlushE       = 1'b1;
        bus.BranchE      = 1'b0;
        bus.BranchTakenE = 1'b0;
        bus.ALUResultE   = 32'd0;
        bus.PCPlus8E     = 32'd0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
        m_pt_d = 1'b0; m_pt_e = 1'b0; m_tg_d = 0; m_tg_e = 0;
    endtask

    // Check outputs for the currently applied inputs, then clock once and advance the model.
    task automatic cyc(input string tag);
        int unsigned fi, ei, fppc, pc, alu;
        bit fhit, fpt, ehit, exp_wrong, br, tk, sd, se, fd, fe, rst;
        #1;
        fi   = (bus.PCF >> 2) % 16;
        fhit = (m_valid[fi] != 0) && (m_tag[fi] == (bus.PCF >> 6));
        fpt  = fhit && (m_ctr[fi] >= 2);
        fppc = fhit ? m_tgt[fi] : 0;
        br = bus.BranchE; tk = bus.BranchTakenE; alu = bus.ALUResultE;
        sd = bus.StallD; se = bus.StallE; fd = bus.FlushD; fe = bus.FlushE; rst = reset;
        if (br) exp_wrong = (m_pt_e != tk) || (m_pt_e && tk && (m_tg_e != alu));
        else    exp_wrong = m_pt_e;
        check_eq({tag, ".is_branchF"},  {31'd0, bus.is_branchF},       {31'd0, fhit});
        check_eq({tag, ".PredictTaken"},{31'd0, bus.PredictTakenF},    {31'd0, fpt});
        check_eq({tag, ".PredictedPC"}, bus.PredictedBranchPC,         fppc);
        check_eq({tag, ".WrongPred"},   {31'd0, bus.WrongPredictionE}, {31'd0, exp_wrong});
        pc   = bus.PCPlus8E - 32'd8;
        ei   = (pc >> 2) % 16;
        ehit = (m_valid[ei] != 0) && (m_tag[ei] == (pc >> 6));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (!se) begin
                if (br && ehit) begin
                    if (tk) begin
                        m_ctr[ei] = (m_ctr[ei] == 3) ? 3 : m_ctr[ei] + 1;
                        m_tgt[ei] = alu;
                    end else begin
                        m_ctr[ei] = (m_ctr[ei] == 0) ? 0 : m_ctr[ei] - 1;
                    end
                end else if (br && tk) begin
                    m_valid[ei] = 1; m_tag[ei] = pc >> 6; m_tgt[ei] = alu; m_ctr[ei] = 2;
                end else if (!br && m_pt_e && ehit) begin
                    m_valid[ei] = 0;
                end
            end
            if (fe) begin
                m_pt_e = 1'b0; m_tg_e = 0;
            end else if (!se) begin
                m_pt_e = m_pt_d; m_tg_e = m_tg_d;
            end
            if (fd) begin
                m_pt_d = 1'b0; m_tg_d = 0;
            end else if (!sd) begin
                m_pt_d = fpt; m_tg_d = fppc;
            end
        end
        #1;
    endtask

    task automatic resolve(input string tag, input bit taken, input logic [31:0] target);
        set_idle();
        bus.BranchE = 1'b1; bus.BranchTakenE = taken;
        bus.PCPlus8E = 32'h108; bus.ALUResultE = target;
        cyc(tag);
        set_idle();
        bus.PCF = 32'h100;
        cyc({tag, "_look"});
    endtask

    initial begin
        model_reset();
        set_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset");
        reset = 1'b0;

        bus.PCF = 32'h100;
        cyc("after_reset");

        // Miss-and-taken allocates at weak-taken; the same cycle's lookup still misses.
        set_idle();
        bus.PCF = 32'h100; bus.BranchE = 1'b1; bus.BranchTakenE = 1'b1;
        bus.PCPlus8E = 32'h108; bus.ALUResultE = 32'h200;
        cyc("alloc");
        set_idle();
        bus.PCF = 32'h100;
        cyc("alloc_hit");

        for (int i = 0; i < 3; i++) resolve("not_taken", 1'b0, 32'h0);
        resolve("retrain1", 1'b1, 32'h200);
        resolve("retrain2", 1'b1, 32'h200);

        // Predicted taken to 0x200, actually taken to 0x300.
        set_idle(); bus.FlushD = 1'b0; bus.FlushE = 1'b0;
        bus.PCF = 32'h100; cyc("tgt_f");
        bus.PCF = 32'h0;   cyc("tgt_d");
        bus.BranchE = 1'b1; bus.BranchTakenE = 1'b1;
        bus.PCPlus8E = 32'h108; bus.ALUResultE = 32'h300;
        cyc("tgt_wrong");
        set_idle(); bus.PCF = 32'h100; cyc("tgt_new");
        resolve("strong_check", 1'b0, 32'h0);

        // Alias: a predicted-taken record reaching E on a non-branch invalidates the entry.
        set_idle(); bus.FlushD = 1'b0; bus.FlushE = 1'b0;
        bus.PCF = 32'h140; cyc("alias_miss");
        bus.PCF = 32'h100; cyc("alias_f");
        bus.PCF = 32'h0;   cyc("alias_d");
        bus.PCPlus8E = 32'h108;
        cyc("alias_e");
        set_idle(); bus.PCF = 32'h100; cyc("alias_gone");

        // FlushE kills the record in D; stalled E resolves update the counter once.
        resolve("realloc", 1'b1, 32'h200);
        set_idle(); bus.FlushD = 1'b0; bus.FlushE = 1'b0;
        bus.PCF = 32'h100; cyc("flush_f");
        bus.PCF = 32'h0; bus.FlushE = 1'b1; cyc("flush_d");
        bus.FlushE = 1'b0; cyc("flush_e");
        set_idle(); bus.FlushD = 1'b0; bus.FlushE = 1'b0;
        bus.StallE = 1'b1; bus.BranchE = 1'b1; bus.BranchTakenE = 1'b0; bus.PCPlus8E = 32'h108;
        for (int i = 0; i < 3; i++) cyc("stall");
        bus.StallE = 1'b0; cyc("stall_release");
        set_idle(); bus.PCF = 32'h100; cyc("stall_look");
        resolve("stall_once", 1'b1, 32'h200);

        // Randomized traffic over a small aliasing address pool.
        for (int n = 0; n < 3000; n++) begin
            bus.PCF          = 32'h100 + 32'd4 * $urandom_range(0, 31);
            bus.PCPlus8E     = 32'h108 + 32'd4 * $urandom_range(0, 31);
            bus.ALUResultE   = 32'h200 + 32'h100 * $urandom_range(0, 2);
            bus.BranchE      = ($urandom_range(0, 2) != 0);
            bus.BranchTakenE = $urandom_range(0, 1);
            bus.StallD       = ($urandom_range(0, 7) == 0);
            bus.StallE       = ($urandom_range(0, 7) == 0);
            bus.FlushD       = ($urandom_range(0, 7) == 0);
            bus.FlushE       = ($urandom_range(0, 7) == 0);
            reset            = ($urandom_range(0, 199) == 0);
            cyc("random");
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, BTB entry count (power of two, 4..64).
REQ-002 Parameter IDXW, default 4, index width, equal to log2(ENTRIES).
REQ-003 clk  in  1  single clock; every register updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 PCF  in  32  fetch-stage PC.
REQ-006 StallD / StallE  in  1 each  hold the D / E prediction registers.
REQ-007 FlushD / FlushE  in  1 each  clear the D / E prediction registers.
REQ-008 BranchE  in  1  E-stage instruction is a branch (condition already evaluated).
REQ-009 BranchTakenE  in  1  actual outcome of the E-stage branch.
REQ-010 ALUResultE  in  32  actual branch target.
REQ-011 PCPlus8E  in  32  PC+8 of the E-stage instruction.
REQ-012 is_branchF  out  1  BTB hit for PCF.
REQ-013 PredictTakenF  out  1  prediction for PCF.
REQ-014 PredictedBranchPC  out  32  predicted target for PCF.
REQ-015 WrongPredictionE  out  1  E-stage prediction was wrong.

Function
REQ-016 The BTB entry SHALL be {valid, tag = PC[31:IDXW+2], target[31:0], ctr[1:0]}, indexed by PC[IDXW+1:2].
REQ-017 Lookup SHALL be combinational: is_branchF = valid & tag match; PredictTakenF = is_branchF & ctr[1]; PredictedBranchPC = target when hit, else 0.
REQ-018 Counter encoding SHALL be 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; counters saturate at 00 and 11.
REQ-019 The prediction record {PredTaken, PredTarget} SHALL advance F->D->E one stage per cycle.
REQ-020 A stall SHALL hold its stage register; a flush SHALL clear it to zero; flush SHALL take priority over stall.
REQ-021 With BranchE=1, WrongPredictionE SHALL be (PredTakenE != BranchTakenE) | (PredTakenE & BranchTakenE & PredTargetE != ALUResultE).
REQ-022 With BranchE=0, WrongPredictionE SHALL equal PredTakenE (alias recovery); the output is combinational from E registers and inputs.
REQ-023 Branch address SHALL be PCPlus8E - 8 (32-bit, wrap-around).
REQ-024 Update on a BranchE hit SHALL increment ctr if taken and decrement it if not taken; target <= ALUResultE when taken.
REQ-025 Update on a BranchE miss SHALL, if taken, allocate {valid=1, tag, target=ALUResultE, ctr=10}, overwriting the index; if not taken, no write.
REQ-026 BranchE=0 with PredTakenE=1 SHALL clear valid of the matching index if its tag matches.
REQ-027 Writes SHALL take effect at the clock edge; a same-cycle lookup of the updated index SHALL return the pre-update contents.
REQ-028 Updates SHALL be suppressed while StallE=1, so that each E instruction updates exactly once.

Reset
REQ-029 Reset SHALL clear all valid bits, counters, targets and tags, and the D/E prediction registers.
REQ-030 After reset, all outputs SHALL read 0 until the first allocation.
REQ-031 Reset asserted mid-operation SHALL override any same-cycle update, stall or flush.

Structure
REQ-032 Package bp_pkg SHALL hold the counter encoding constants, the entry typedef, and the default ENTRIES/IDXW values.
REQ-033 Sub-module sat_counter2 (2-bit saturating update, taken in -> next ctr) SHALL be used; the BTB array and pipeline registers SHALL be inline.

Verification
REQ-034 Reset, then PCF=0x100 -> is_branchF=0, PredictTakenF=0, PredictedBranchPC=0.
REQ-035 BranchE=1, taken, PCPlus8E=0x108, ALUResultE=0x200 with miss -> WrongPredictionE=1 and allocate ctr=10; then PCF=0x100 -> hit, PredictTakenF=1, PredictedBranchPC=0x200.
REQ-036 Entry ctr=10 with two not-taken resolves -> ctr 01 then 00; PredictTakenF=0; third not-taken -> stays 00.
REQ-037 Predicted taken to 0x200, actual taken to 0x300 -> WrongPredictionE=1; target becomes 0x300; ctr becomes 11.
REQ-038 PCF=0x140 aliases entry 0x100 (ENTRIES=16); E-stage non-branch with PredTakenE=1 -> WrongPredictionE=1 and entry invalidated.
REQ-039 FlushE asserted with a predicted-taken record in D -> next-cycle WrongPredictionE=0; StallE held 3 cycles -> counter changes once.
